// File: rtl/mult_stream_controller.sv
// Valid/ready front end for the registered 32x32 signed multiplier wrapper:
// sequences operand capture, the output-register enable and the result hand-off.
module mult_stream_controller #(
  parameter int MUL_LATENCY = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  flush,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic signed [31:0]    inA,
  input  logic signed [31:0]    inB,
  output logic signed [31:0]    opA,
  output logic signed [31:0]    opB,
  output logic                  enableA,
  output logic                  enableB,
  output logic                  enableOut,
  output logic                  clearMul,
  input  logic signed [63:0]    productIn,
  output logic                  outValid,
  input  logic                  outReady,
  output logic signed [63:0]    outProduct,
  output logic [CNT_WIDTH-1:0]  txnCount
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] CAPT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  // A single-cycle multiplier skips WAIT entirely; otherwise WAIT lasts MUL_LATENCY-1 cycles.
  localparam int         WAIT_INIT_INT = (MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0;
  localparam logic [3:0] WAIT_INIT     = WAIT_INIT_INT[3:0];
  localparam logic [1:0] LAUNCH_STATE  = (MUL_LATENCY == 1) ? CAPT : WAIT;

  logic [1:0]           r_state;
  logic [3:0]           r_waitCnt;
  logic                 r_clearMul;
  logic [CNT_WIDTH-1:0] r_txnCount;

  logic                 w_acc;
  logic                 w_done;
  logic [1:0]           w_nextState;
  logic [3:0]           w_nextWait;

  assign inReady    = !r_clearMul && ((r_state == IDLE) || ((r_state == HOLD) && outReady));
  assign w_acc      = inValid && inReady;
  assign w_done     = (r_state == HOLD) && outReady;

  assign enableA    = w_acc;
  assign enableB    = w_acc;
  assign enableOut  = (r_state == CAPT);
  assign outValid   = (r_state == HOLD);
  assign clearMul   = r_clearMul;
  assign opA        = inA;
  assign opB        = inB;
  assign outProduct = productIn;
  assign txnCount   = r_txnCount;

  always_comb begin
    w_nextState = r_state;
    w_nextWait  = r_waitCnt;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_nextState = LAUNCH_STATE;
          w_nextWait  = WAIT_INIT;
        end
      end
      WAIT: begin
        if (r_waitCnt == 4'd0) begin
          w_nextState = CAPT;
        end else begin
          w_nextWait = r_waitCnt - 4'd1;
        end
      end
      CAPT: w_nextState = HOLD;
      HOLD: begin
        if (w_done) begin
          if (w_acc) begin
            w_nextState = LAUNCH_STATE;
            w_nextWait  = WAIT_INIT;
          end else begin
            w_nextState = IDLE;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
    // Flush wins over any accept or completion seen in the same cycle.
    if (flush) begin
      w_nextState = IDLE;
      w_nextWait  = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= IDLE;
      r_waitCnt  <= 4'd0;
      r_clearMul <= 1'b1;
      r_txnCount <= '0;
    end else begin
      r_state    <= w_nextState;
      r_waitCnt  <= w_nextWait;
      r_clearMul <= flush;
      if (w_done && !flush) begin
        r_txnCount <= r_txnCount + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_mult_stream_controller.sv
// Randomized scoreboard bench for mult_stream_controller: two instances
// (single-cycle multiplier with a 16-bit counter, 3-cycle multiplier with a 2-bit counter).
module tb_mult_stream_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int doneCount   = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_h
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam int CW  = (g == 0) ? 16 : 2;

    logic               resetN, flush, inValid, inReady, outReady;
    logic               enableA, enableB, enableOut, clearMul, outValid;
    logic signed [31:0] inA, inB, opA, opB;
    logic signed [63:0] productIn, outProduct;
    logic [CW-1:0]      txnCount;

    logic signed [31:0] mulA, mulB;
    logic signed [63:0] mulP;
    longint             expQ[$];
    int                 modelCnt = 0;
    bit                 randReady = 1'b0;

    mult_stream_controller #(.MUL_LATENCY(LAT), .CNT_WIDTH(CW)) u_dut (
      .clk(clk), .resetN(resetN), .flush(flush),
      .inValid(inValid), .inReady(inReady), .inA(inA), .inB(inB),
      .opA(opA), .opB(opB), .enableA(enableA), .enableB(enableB),
      .enableOut(enableOut), .clearMul(clearMul), .productIn(productIn),
      .outValid(outValid), .outReady(outReady), .outProduct(outProduct),
      .txnCount(txnCount)
    );

    // Behavioural stand-in for the registered multiplier wrapper the controller drives.
    always @(posedge clk) begin
      if (clearMul) begin
        mulA <= '0;
        mulB <= '0;
        mulP <= '0;
      end else begin
        if (enableA) mulA <= opA;
        if (enableB) mulB <= opB;
        if (enableOut) mulP <= longint'(mulA) * longint'(mulB);
      end
    end
    assign productIn = mulP;

    initial forever begin
      @(negedge clk);
      if (randReady) outReady = ($urandom_range(0, 3) != 0);
    end

    // Monitor: compares every presented result against the queue head and tracks completions.
    initial forever begin
      @(negedge clk);
      #1;
      if (resetN !== 1'b1) begin
        expQ.delete();
        modelCnt = 0;
        checkOutput($sformatf("h%0d_rstOutValid", g), outValid, 0);
        checkOutput($sformatf("h%0d_rstInReady", g), inReady, 0);
        checkOutput($sformatf("h%0d_rstEnableOut", g), enableOut, 0);
      end else begin
        checkOutput($sformatf("h%0d_txnCount", g), txnCount, 64'(modelCnt % (1 << CW)));
        if (flush) begin
          expQ.delete();
        end else if (outValid) begin
          if (expQ.size() == 0) begin
            checkOutput($sformatf("h%0d_unexpectedResult", g), 1, 0);
          end else begin
            checkOutput($sformatf("h%0d_outProduct", g), outProduct, expQ[0]);
            if (outReady) begin
              void'(expQ.pop_front());
              modelCnt++;
            end
          end
        end
      end
    end

    task automatic applyStimulus(input logic signed [31:0] a, input logic signed [31:0] b);
      int n = 0;
      @(negedge clk);
      inValid = 1'b1;
      inA = a;
      inB = b;
      #1;
      while (!inReady && n < 200) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (!inReady) begin
        checkOutput($sformatf("h%0d_acceptTimeout", g), 0, 1);
      end else begin
        expQ.push_back(longint'(a) * longint'(b));
        @(posedge clk);
        #1;
      end
      inValid = 1'b0;
    endtask

    task automatic waitValid();
      int n = 0;
      do begin
        @(negedge clk);
        #1;
        n++;
      end while (!outValid && n < 100);
      if (!outValid) checkOutput($sformatf("h%0d_outValidTimeout", g), 0, 1);
    endtask

    task automatic drain();
      int n = 0;
      while (expQ.size() != 0 && n < 500) begin
        @(negedge clk);
        #2;
        n++;
      end
      if (expQ.size() != 0) checkOutput($sformatf("h%0d_drainTimeout", g), 0, 1);
      @(posedge clk);
      #1;
    endtask

    initial begin
      longint t0, t1;
      logic signed [31:0] pairA[4];
      logic signed [31:0] pairB[4];
      pairA = '{32'sh7FFFFFFF, 32'sh80000000, 32'sd0, -32'sd1};
      pairB = '{32'sd2, 32'sh80000000, 32'sd5, -32'sd1};

      resetN = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
      inA = '0; inB = '0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput($sformatf("h%0d_rstClearMul", g), clearMul, 1);
      @(negedge clk);
      resetN = 1'b1;
      inValid = 1'b1;
      #1;
      checkOutput($sformatf("h%0d_relClearMul", g), clearMul, 1);
      checkOutput($sformatf("h%0d_relInReady", g), inReady, 0);
      checkOutput($sformatf("h%0d_relEnableA", g), enableA, 0);
      inValid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput($sformatf("h%0d_postClearMul", g), clearMul, 0);
      checkOutput($sformatf("h%0d_postInReady", g), inReady, 1);

      // Single op: pipeline timing from the accept edge.
      applyStimulus(-32'sd3, 32'sd7);
      for (int k = 1; k <= LAT + 1; k++) begin
        checkOutput($sformatf("h%0d_enableOutAt%0d", g, k), enableOut, 64'(k == LAT));
        checkOutput($sformatf("h%0d_outValidAt%0d", g, k), outValid, 64'(k == LAT + 1));
        checkOutput($sformatf("h%0d_enableABAt%0d", g, k), enableA | enableB, 0);
        if (k <= LAT) begin
          @(posedge clk);
          #1;
        end
      end
      checkOutput($sformatf("h%0d_firstProduct", g), outProduct, 64'hFFFFFFFFFFFFFFEB);
      @(posedge clk);
      #1;
      checkOutput($sformatf("h%0d_firstCount", g), txnCount, 1);

      // Back-to-back stream: one accept every LAT+1 cycles.
      for (int i = 0; i < 4; i++) begin
        applyStimulus(pairA[i], pairB[i]);
        t1 = $time;
        if (i > 0) checkOutput($sformatf("h%0d_b2bSpacing%0d", g, i), t1 - t0, 64'((LAT + 1) * 10));
        t0 = t1;
      end
      drain();
      checkOutput($sformatf("h%0d_b2bCount", g), txnCount, 64'(5 % (1 << CW)));

      // Back-pressure: result held, no accepts, no enables.
      outReady = 1'b0;
      applyStimulus(32'sd123456, -32'sd789);
      waitValid();
      @(negedge clk);
      inValid = 1'b1;
      inA = 32'sd99;
      inB = 32'sd98;
      for (int k = 0; k < 5; k++) begin
        #1;
        checkOutput($sformatf("h%0d_bpInReady", g), inReady, 0);
        checkOutput($sformatf("h%0d_bpEnableA", g), enableA | enableB, 0);
        checkOutput($sformatf("h%0d_bpOutValid", g), outValid, 1);
        @(negedge clk);
      end
      inValid = 1'b0;
      outReady = 1'b1;
      drain();
      checkOutput($sformatf("h%0d_bpCount", g), txnCount, 64'(6 % (1 << CW)));

      // Flush right after accept (WAIT or CAPT), then flush in HOLD overriding completion.
      applyStimulus(32'sd11, 32'sd13);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      checkOutput($sformatf("h%0d_flushClearMul", g), clearMul, 1);
      checkOutput($sformatf("h%0d_flushInReady", g), inReady, 0);
      @(negedge clk);
      flush = 1'b0;
      repeat (LAT + 3) @(negedge clk);
      outReady = 1'b0;
      applyStimulus(32'sd17, 32'sd19);
      waitValid();
      @(negedge clk);
      flush = 1'b1;
      outReady = 1'b1;
      @(posedge clk);
      #1;
      checkOutput($sformatf("h%0d_flushHoldValid", g), outValid, 0);
      checkOutput($sformatf("h%0d_flushHoldClear", g), clearMul, 1);
      @(negedge clk);
      flush = 1'b0;
      repeat (LAT + 3) @(negedge clk);
      applyStimulus(-32'sd100, 32'sd100);
      drain();
      checkOutput($sformatf("h%0d_flushCount", g), txnCount, 64'(7 % (1 << CW)));

      // Random stream with random back-pressure.
      randReady = 1'b1;
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        applyStimulus($urandom, (i % 8 == 0) ? 32'sh80000000 : 32'($urandom));
      end
      randReady = 1'b0;
      @(negedge clk);
      outReady = 1'b1;
      drain();
      checkOutput($sformatf("h%0d_randCount", g), txnCount, 64'(47 % (1 << CW)));

      // Asynchronous reset while a result is held.
      outReady = 1'b0;
      applyStimulus(32'sd5, 32'sd6);
      waitValid();
      @(posedge clk);
      #3;
      resetN = 1'b0;
      #1;
      checkOutput($sformatf("h%0d_asyncOutValid", g), outValid, 0);
      checkOutput($sformatf("h%0d_asyncClearMul", g), clearMul, 1);
      checkOutput($sformatf("h%0d_asyncCount", g), txnCount, 0);
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      outReady = 1'b1;
      repeat (2) @(negedge clk);
      doneCount++;
    end
  end

  initial begin
    int t = 0;
    while (doneCount < 2 && t < 50000) begin
      @(posedge clk);
      t++;
    end
    if (doneCount < 2) checkOutput("globalTimeout", 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
